// File: rtl/draw_rect_frame_if.sv
// Request/pixel bundle for the rectangle frame drawer.
// master issues draw requests and consumes pixels; slave is the draw engine.
interface draw_rect_frame_if #(
   parameter int X_W = 8,
   parameter int Y_W = 7,
   parameter int C_W = 3,
   parameter int T_W = 4
);
   logic           start;
   logic           abort;
   logic [X_W-1:0] x0;
   logic [Y_W-1:0] y0;
   logic [X_W-1:0] w;
   logic [Y_W-1:0] h;
   logic [T_W-1:0] thick;
   logic [C_W-1:0] color;
   logic           fill_en;
   logic [C_W-1:0] fill_color;
   logic           busy;
   logic           done;
   logic           writeEn;
   logic [X_W-1:0] x_out;
   logic [Y_W-1:0] y_out;
   logic [C_W-1:0] color_out;

   modport master (
      output start, abort, x0, y0, w, h, thick, color, fill_en, fill_color,
      input  busy, done, writeEn, x_out, y_out, color_out
   );

   modport slave (
      input  start, abort, x0, y0, w, h, thick, color, fill_en, fill_color,
      output busy, done, writeEn, x_out, y_out, color_out
   );
endinterface

// File: rtl/draw_rect_frame.sv
// Raster-scans a rectangle one cell per cycle, emitting border/interior pixels
// with screen clipping; outline mode jumps straight over the interior span.
module draw_rect_frame #(
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int C_W      = 3,
   parameter int T_W      = 4,
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120
) (
   input  logic               clk,
   input  logic               reset,
   draw_rect_frame_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

   // Wide enough that col+t, row+t and 2t never wrap.
   localparam int XW = ((X_W > T_W) ? X_W : T_W) + 2;
   localparam int YW = ((Y_W > T_W) ? Y_W : T_W) + 2;

   typedef struct packed {
      logic [X_W-1:0] x0;
      logic [Y_W-1:0] y0;
      logic [X_W-1:0] w;
      logic [Y_W-1:0] h;
      logic [T_W-1:0] t;
      logic [C_W-1:0] color;
      logic           fill_en;
      logic [C_W-1:0] fill_color;
   } req_t;

   state_t         state, state_nxt;
   req_t           req;
   logic [X_W-1:0] col;
   logic [Y_W-1:0] row;

   logic [XW-1:0]  col_e, w_e, tx_e;
   logic [YW-1:0]  row_e, h_e, ty_e;
   logic           col_int, row_int, interior;
   logic           last_col, last_row, skip;
   logic [X_W:0]   px;
   logic [Y_W:0]   py;
   logic           on_screen;
   logic           empty_req;

   assign col_e = XW'(col);
   assign row_e = YW'(row);
   assign w_e   = XW'(req.w);
   assign h_e   = YW'(req.h);
   assign tx_e  = XW'(req.t);
   assign ty_e  = YW'(req.t);

   assign col_int  = (col_e >= tx_e) && ((col_e + tx_e) < w_e);
   assign row_int  = (row_e >= ty_e) && ((row_e + ty_e) < h_e);
   assign interior = col_int && row_int;

   assign last_col = (col == (req.w - X_W'(1)));
   assign last_row = (row == (req.h - Y_W'(1)));

   // Jump from the last left-border cell to the first right-border cell, but
   // only when an interior span actually exists (2t < w), else it would rewind.
   assign skip = !req.fill_en && row_int && ((col_e + XW'(1)) == tx_e) &&
                 ((tx_e << 1) < w_e);

   assign px        = (X_W+1)'(req.x0) + (X_W+1)'(col);
   assign py        = (Y_W+1)'(req.y0) + (Y_W+1)'(row);
   assign on_screen = (px < (X_W+1)'(SCREEN_W)) && (py < (Y_W+1)'(SCREEN_H));

   assign empty_req = (bus.w == '0) || (bus.h == '0);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (bus.start) state_nxt = empty_req ? DONE : DRAW;
         DRAW: begin
            if (bus.abort)                 state_nxt = IDLE;
            else if (last_col && last_row) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.busy      = 1'b0;
      bus.done      = 1'b0;
      bus.writeEn   = 1'b0;
      bus.x_out     = '0;
      bus.y_out     = '0;
      bus.color_out = '0;
      if (!reset) begin
         case (state)
            DRAW: begin
               bus.busy      = 1'b1;
               bus.writeEn   = on_screen;
               bus.x_out     = px[X_W-1:0];
               bus.y_out     = py[Y_W-1:0];
               bus.color_out = (interior && req.fill_en) ? req.fill_color : req.color;
            end
            DONE:    bus.done = 1'b1;
            default: ;
         endcase
      end
   end

   // Request latch and raster cursor.
   always_ff @(posedge clk) begin
      if (reset) begin
         req <= '0;
         col <= '0;
         row <= '0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               req.x0         <= bus.x0;
               req.y0         <= bus.y0;
               req.w          <= bus.w;
               req.h          <= bus.h;
               req.t          <= (bus.thick == '0) ? T_W'(1) : bus.thick;
               req.color      <= bus.color;
               req.fill_en    <= bus.fill_en;
               req.fill_color <= bus.fill_color;
               col            <= '0;
               row            <= '0;
            end
            DRAW: if (!bus.abort) begin
               if (last_col) begin
                  col <= '0;
                  row <= row + Y_W'(1);
               end else if (skip) begin
                  col <= req.w - X_W'(req.t);
               end else begin
                  col <= col + X_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/draw_rect_frame.md
DRAW_RECT_FRAME -- requirements
Module: draw_rect_frame

Interface
REQ-001 SHALL have parameter X_W, default 8, x-coordinate width.
REQ-002 SHALL have parameter Y_W, default 7, y-coordinate width.
REQ-003 SHALL have parameter C_W, default 3, colour width.
REQ-004 SHALL have parameter T_W, default 4, border-thickness width.
REQ-005 SHALL have parameters SCREEN_W, default 160, and SCREEN_H, default 120, the visible-area limits.
REQ-006 SHALL have ports as follows:
- clk  in  1  sole clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request draw, sampled in IDLE only.
- abort  in  1  cancel current draw.
- x0  in  X_W  top-left x.
- y0  in  Y_W  top-left y.
- w  in  X_W  rectangle width (pixels).
- h  in  Y_W  rectangle height (pixels).
- thick  in  T_W  border thickness.
- color  in  C_W  border colour.
- fill_en  in  1  1 = filled mode, 0 = outline mode.
- fill_color  in  C_W  interior colour.
- busy  out  1  high in DRAW.
- done  out  1  one-cycle completion pulse.
- writeEn  out  1  pixel-write strobe.
- x_out  out  X_W  pixel x.
- y_out  out  Y_W  pixel y.
- color_out  out  C_W  pixel colour.

Function
REQ-007 SHALL implement FSM IDLE -> DRAW -> DONE -> IDLE.
REQ-008 SHALL, in IDLE with start=1, latch x0, y0, w, h, thick, color, fill_en and fill_color, reset cursor (col,row) to (0,0), and enter DRAW next cycle; inputs SHALL be ignored at all other times.
REQ-009 SHALL, in IDLE with start=1 and (w==0 or h==0), go straight to DONE with no writes.
REQ-010 SHALL treat latched thick==0 as 1.
REQ-011 SHALL classify a cell as interior iff col>=t, col<w-t, row>=t and row<h-t (t = effective thickness); all comparisons SHALL be done at widths wide enough that none wraps.
REQ-012 SHALL visit one cell per DRAW cycle in raster order (col fastest); it SHALL present x_out=x0+col, y_out=y0+row, with color_out=color for border cells and fill_color for interior cells.
REQ-013 SHALL, in outline mode, skip interior cells: on the interior row whose cell col==t-1 is visited, the next col SHALL be w-t; no cycle SHALL be spent on an interior cell.
REQ-014 SHALL assert writeEn in DRAW iff the presented pixel satisfies x0+col < SCREEN_W and y0+row < SCREEN_H, computed at X_W+1 and Y_W+1 bits; clipped cells SHALL still consume their cycle.
REQ-015 SHALL go from DRAW to DONE the cycle after the last cell, (w-1,h-1).
REQ-016 SHALL pulse done high in DONE for exactly one cycle and return to IDLE; start in DONE SHALL be ignored.
REQ-017 SHALL drive busy=1 exactly in DRAW.
REQ-018 SHALL drive writeEn=0 in IDLE and DONE.
REQ-019 SHALL, on abort=1 in DRAW, return to IDLE next cycle with writeEn=0 that cycle and no done pulse; abort SHALL be ignored outside DRAW and SHALL take priority over the DRAW-to-DONE transition.
REQ-020 SHALL produce a filled-mode draw of exactly w*h DRAW cycles.
REQ-021 SHALL produce an outline-mode draw of exactly w*h-(w-2t)*(h-2t) DRAW cycles when 2t<w and 2t<h, else w*h.

Reset
REQ-022 SHALL, with reset=1 at a clock edge, enter IDLE and clear cursor and latched registers; this SHALL override start and abort and apply mid-draw.
REQ-023 SHALL drive writeEn=0, done=0, busy=0, x_out=0, y_out=0 and color_out=0 while in reset and in IDLE.

Verification
REQ-024 Outline x0=10,y0=5,w=4,h=3,thick=1,color=7: 10 writes, (10..13,5), (10,6), (13,6), (10..13,7); done on the 11th cycle after start.
REQ-025 Same with fill_en=1, fill_color=2: 12 writes; (11,6) and (12,6) have colour 2; done on the 13th cycle.
REQ-026 Outline w=6,h=6,thick=3: 36 writes, all colour=color; thick=0 with w=3,h=3 yields 8 writes.
REQ-027 Clipping x0=158,y0=118,w=4,h=4, filled: 16 DRAW cycles, writeEn high only for x in 158..159 and y in 118..119 (4 writes).
REQ-028 abort in the 3rd DRAW cycle: busy low next cycle, no done, then a new start draws normally; w=0 gives done 1 cycle after start with 0 writes.
REQ-029 reset asserted mid-draw: next cycle all outputs are 0, state is IDLE, and start during DRAW/DONE has no effect.
